// File: rtl/detector_regioes_pkg.sv
// Shared types and constants for the multi-region coordinate detector.
package detector_regioes_pkg;

    localparam int LARGURA_PADRAO = 10;
    localparam int N_REG_PADRAO   = 4;
    // Bounds are stored at this width; narrower coordinates are zero-extended.
    localparam int LARGURA_MAX    = 16;
    localparam int CONTAGEM_W     = 16;

    // Region index width: clog2 with a floor of one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [LARGURA_MAX-1:0] x_ini;
        logic [LARGURA_MAX-1:0] x_fim;
        logic [LARGURA_MAX-1:0] y_ini;
        logic [LARGURA_MAX-1:0] y_fim;
        logic                   hab;
    } regiao_t;

endpackage

// File: rtl/detector_regioes_pipe_comparador.sv
// Half-open interval test on one axis: ini <= v < fim, unsigned.
// An empty interval (fim <= ini) and fim = 0 fall out naturally as never-hit.
module comparador_intervalo #(
    parameter int LARGURA = 10
) (
    input  logic [LARGURA-1:0] v,
    input  logic [LARGURA-1:0] ini,
    input  logic [LARGURA-1:0] fim,
    output logic               dentro
);

    assign dentro = (v >= ini) && (v < fim);

endmodule

// File: rtl/detector_regioes_pipe.sv
// Tests each (x, y) against N_REG programmable rectangles, two-stage pipeline.
// Optional hit counter enabled by defining CONTA_ACERTOS_EN.
module detector_regioes_pipe
    import detector_regioes_pkg::*;
#(
    parameter  int LARGURA = LARGURA_PADRAO,
    parameter  int N_REG   = N_REG_PADRAO,
    localparam int IDX_W   = idx_w(N_REG)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [LARGURA-1:0] cfg_x_ini,
    input  logic [LARGURA-1:0] cfg_x_fim,
    input  logic [LARGURA-1:0] cfg_y_ini,
    input  logic [LARGURA-1:0] cfg_y_fim,
    input  logic               cfg_hab,
    input  logic               entrada_valida,
    input  logic [LARGURA-1:0] x,
    input  logic [LARGURA-1:0] y,
`ifdef CONTA_ACERTOS_EN
    input  logic                  zera_contagem,
    output logic [CONTAGEM_W-1:0] contagem,
`endif
    output logic               saida_valida,
    output logic [N_REG-1:0]   dentro,
    output logic               algum,
    output logic [IDX_W-1:0]   indice
);

    localparam int STAGES = 2;

    regiao_t            regs [N_REG];
    logic [N_REG-1:0]   x_ok, y_ok, hab_vec;
    logic [N_REG-1:0]   x_ok_q, y_ok_q, hab_q;
    logic [N_REG-1:0]   dentro_c;
    logic [STAGES:1]    vld_pipe;

    // Lowest set bit wins.
    function automatic logic [IDX_W-1:0] prio(input logic [N_REG-1:0] v);
        prio = '0;
        for (int i = N_REG - 1; i >= 0; i--)
            if (v[i]) prio = IDX_W'(i);
    endfunction

    // Region bound registers; out-of-range indices match no entry and are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REG; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < N_REG; i++) begin
                if (cfg_we && cfg_idx == IDX_W'(i)) begin
                    regs[i].x_ini <= LARGURA_MAX'(cfg_x_ini);
                    regs[i].x_fim <= LARGURA_MAX'(cfg_x_fim);
                    regs[i].y_ini <= LARGURA_MAX'(cfg_y_ini);
                    regs[i].y_fim <= LARGURA_MAX'(cfg_y_fim);
                    regs[i].hab   <= cfg_hab;
                end
            end
        end
    end

    // One comparator per axis per region, fed from the current (pre-write) bounds.
    for (genvar g = 0; g < N_REG; g++) begin : g_reg
        comparador_intervalo #(.LARGURA(LARGURA)) u_cx (
            .v(x), .ini(regs[g].x_ini[LARGURA-1:0]), .fim(regs[g].x_fim[LARGURA-1:0]),
            .dentro(x_ok[g])
        );
        comparador_intervalo #(.LARGURA(LARGURA)) u_cy (
            .v(y), .ini(regs[g].y_ini[LARGURA-1:0]), .fim(regs[g].y_fim[LARGURA-1:0]),
            .dentro(y_ok[g])
        );
        assign hab_vec[g] = regs[g].hab;
    end

    // Valid shift register; reset drops anything in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[STAGES-1:1], entrada_valida};
    end

    // Stage 1: capture per-axis results and an enable snapshot; hold on bubbles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_ok_q <= '0;
            y_ok_q <= '0;
            hab_q  <= '0;
        end else if (entrada_valida) begin
            x_ok_q <= x_ok;
            y_ok_q <= y_ok;
            hab_q  <= hab_vec;
        end
    end

    assign dentro_c = x_ok_q & y_ok_q & hab_q;

    // Stage 2: combine, reduce and priority-encode; hold on bubbles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dentro <= '0;
            algum  <= 1'b0;
            indice <= '0;
        end else if (vld_pipe[1]) begin
            dentro <= dentro_c;
            algum  <= |dentro_c;
            indice <= prio(dentro_c);
        end
    end

    assign saida_valida = vld_pipe[STAGES];

`ifdef CONTA_ACERTOS_EN
    // Saturating count of valid results with any hit; clear wins over increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                   contagem <= '0;
        else if (zera_contagem)                         contagem <= '0;
        else if (vld_pipe[STAGES] && algum && contagem != '1) contagem <= contagem + 1'b1;
    end
`endif

endmodule

// File: tb/tb_detector_regioes_pipe.sv
// Scoreboard bench for detector_regioes_pipe: stimulus pushes expected results,
// a negedge monitor pops and compares whenever saida_valida is high.
module tb_detector_regioes_pipe;

    localparam int LARGURA = 10;
    localparam int N_REG   = 4;
    localparam int IDX_W   = 2;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [IDX_W-1:0]   cfg_idx = '0;
    logic [LARGURA-1:0] cfg_x_ini = '0, cfg_x_fim = '0, cfg_y_ini = '0, cfg_y_fim = '0;
    logic               cfg_hab = 1'b0;
    logic               entrada_valida = 1'b0;
    logic [LARGURA-1:0] x = '0, y = '0;
    logic               saida_valida;
    logic [N_REG-1:0]   dentro;
    logic               algum;
    logic [IDX_W-1:0]   indice;
`ifdef CONTA_ACERTOS_EN
    logic               zera_contagem = 1'b0;
    logic [15:0]        contagem;
`endif

    detector_regioes_pipe #(.LARGURA(LARGURA), .N_REG(N_REG)) dut (
        .clock(clock), .reset_n(reset_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_x_ini(cfg_x_ini), .cfg_x_fim(cfg_x_fim),
        .cfg_y_ini(cfg_y_ini), .cfg_y_fim(cfg_y_fim), .cfg_hab(cfg_hab),
        .entrada_valida(entrada_valida), .x(x), .y(y),
`ifdef CONTA_ACERTOS_EN
        .zera_contagem(zera_contagem), .contagem(contagem),
`endif
        .saida_valida(saida_valida), .dentro(dentro), .algum(algum), .indice(indice)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        int               due;
        logic [N_REG-1:0] dentro;
        logic             algum;
        logic [IDX_W-1:0] indice;
    } esp_t;

    esp_t fila[$];
    bit   sb_off = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, act, exp, cyc);
        end
    endtask

    // Monitor: flags late, missing and unexpected results and checks content.
    always @(negedge clock) begin
        if (reset_n && !sb_off) begin
            while (fila.size() > 0 && fila[0].due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_output: no result, expected due at cycle %0d (now %0d)",
                         fila[0].due, cyc);
                void'(fila.pop_front());
            end
            if (saida_valida) begin
                if (fila.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got saida_valida=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    esp_t e;
                    e = fila.pop_front();
                    chk("latency_cycle", cyc, e.due);
                    chk("dentro", 32'(dentro), 32'(e.dentro));
                    chk("algum", 32'(algum), 32'(e.algum));
                    chk("indice", 32'(indice), 32'(e.indice));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cfg(input int idx, input int xi, input int xf, input int yi,
                           input int yf, input bit hab);
        cfg_we    = 1'b1;
        cfg_idx   = IDX_W'(idx);
        cfg_x_ini = LARGURA'(xi);
        cfg_x_fim = LARGURA'(xf);
        cfg_y_ini = LARGURA'(yi);
        cfg_y_fim = LARGURA'(yf);
        cfg_hab   = hab;
    endtask

    task automatic escreve(input int idx, input int xi, input int xf, input int yi,
                           input int yf, input bit hab);
        set_cfg(idx, xi, xf, yi, yf, hab);
        tick();
        cfg_we = 1'b0;
    endtask

    // Present one coordinate for one cycle; result due two edges later.
    task automatic envia(input int xv, input int yv, input logic [N_REG-1:0] d,
                         input logic a, input int idx);
        x = LARGURA'(xv);
        y = LARGURA'(yv);
        entrada_valida = 1'b1;
        if (!sb_off) fila.push_back('{cyc + 2, d, a, IDX_W'(idx)});
        tick();
    endtask

    task automatic ocioso(input int n);
        entrada_valida = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_saida_valida", 32'(saida_valida), 0);
        chk("rst_dentro", 32'(dentro), 0);
        chk("rst_algum", 32'(algum), 0);
        chk("rst_indice", 32'(indice), 0);
        reset_n = 1'b1;
        tick();

        // No region enabled
        envia(100, 100, 4'b0000, 0, 0);
        ocioso(3);

        // Region 0 x/y [10,20): edge sweep on x
        escreve(0, 10, 20, 10, 20, 1'b1);
        envia(9,  10, 4'b0000, 0, 0);
        envia(10, 10, 4'b0001, 1, 0);
        envia(19, 10, 4'b0001, 1, 0);
        envia(20, 10, 4'b0000, 0, 0);
        ocioso(3);

        // Overlapping regions 1 and 2
        escreve(1, 0, 640, 0, 480, 1'b1);
        escreve(2, 0, 640, 0, 480, 1'b1);
        envia(5, 5, 4'b0110, 1, 1);
        envia(12, 12, 4'b0111, 1, 0);
        ocioso(4);
        // Hold: outputs keep the last result once valid drops
        chk("hold_valid", 32'(saida_valida), 0);
        chk("hold_dentro", 32'(dentro), 32'(4'b0111));

        // Empty region 0 (fim < ini on x)
        escreve(0, 50, 40, 0, 480, 1'b1);
        envia(45, 45, 4'b0110, 1, 1);

        // Write region 3 in the same cycle a coordinate is sampled: old bounds apply
        set_cfg(3, 0, 100, 0, 100, 1'b1);
        envia(12, 12, 4'b0110, 1, 1);
        cfg_we = 1'b0;
        envia(12, 12, 4'b1110, 1, 1);
        envia(639, 479, 4'b0110, 1, 1);
        envia(640, 5, 4'b0000, 0, 0);
        ocioso(3);

        // fim = 0 never hits
        escreve(3, 0, 0, 0, 100, 1'b1);
        envia(0, 0, 4'b0110, 1, 1);
        ocioso(3);

        // Maximum coordinate is never inside
        escreve(3, 0, 1023, 0, 1023, 1'b1);
        envia(1023, 5, 4'b0000, 0, 0);
        envia(1022, 5, 4'b1000, 1, 3);
        ocioso(3);

        // Reset while two coordinates are in flight
        envia(5, 5, 4'b0110, 1, 1);
        envia(6, 6, 4'b0110, 1, 1);
        entrada_valida = 1'b0;
        chk("inflight_valid", 32'(saida_valida), 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(saida_valida), 0);
        chk("midrst_dentro", 32'(dentro), 0);
        fila.delete();
        tick();
        tick();
        reset_n = 1'b1;
        ocioso(4);
        chk("post_rst_valid", 32'(saida_valida), 0);
        // Regions were cleared by reset
        envia(5, 5, 4'b0000, 0, 0);
        ocioso(3);

`ifdef CONTA_ACERTOS_EN
        chk("cnt_start", 32'(contagem), 0);
        escreve(0, 0, 640, 0, 480, 1'b1);
        for (int i = 0; i < 5; i++) envia(1, 1, 4'b0001, 1, 0);
        ocioso(4);
        chk("cnt_five", 32'(contagem), 5);
        envia(1, 1, 4'b0001, 1, 0);
        entrada_valida = 1'b0;
        tick();
        zera_contagem = 1'b1;
        chk("cnt_hit_present", 32'(saida_valida & algum), 1);
        tick();
        zera_contagem = 1'b0;
        chk("cnt_clear_priority", 32'(contagem), 0);
        ocioso(2);
        sb_off = 1'b1;
        x = 1;
        y = 1;
        entrada_valida = 1'b1;
        repeat (65540) tick();
        entrada_valida = 1'b0;
        repeat (4) tick();
        chk("cnt_saturate", 32'(contagem), 32'h0000FFFF);
        sb_off = 1'b0;
`endif

        ocioso(4);
        chk("queue_drained", fila.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
